mem_stage_ctrl: RTL and testbench

Memory-stage controller that consumes the outputs of the EX/MEM pipeline register. It decodes SPARC load/store formats (op=2'b11) and issues a valid/ready request to the data memory. It waits for the response, aligns and extends load data, and drives the MEM/WB-side result signals. It stalls the upstream pipeline while a memory access is in flight. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - SPARC memory-stage controller: load/store decode, dmem handshake, load align/extend, writeback.
module mem_stage_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           ex_target,
  input  logic                  ex_mux_sel,
  input  logic [4:0]            ex_regD,
  input  logic [ADDR_WIDTH-1:0] ex_alures,
  input  logic [1:0]            ex_op,
  input  logic [2:0]            ex_op2,
  input  logic [5:0]            ex_op3,
  input  logic [31:0]           ex_valD,
  output logic                  mem_stall,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic                  dmem_req_we,
  output logic [3:0]            dmem_req_be,
  output logic [31:0]           dmem_req_wdata,
  input  logic                  dmem_resp_valid,
  input  logic [31:0]           dmem_resp_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_regD,
  output logic [31:0]           wb_data,
  output logic                  wb_we,
  output logic [63:0]           wb_target,
  output logic                  wb_mux_sel,
  output logic                  misalign_trap,
  output logic                  bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic       is_mem;
  logic       size_word;
  logic       size_half;
  logic       is_store;
  logic       is_signed;
  logic       misaligned;
  logic [1:0] addr_lo;
  logic [7:0] byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic       unused_op2;

  // op2 only travels along the pipeline; format-3 decode does not need it
  assign unused_op2 = ^ex_op2;

  assign addr_lo = ex_alures[1:0];

  always_comb begin
    is_mem    = 1'b0;
    size_word = 1'b0;
    size_half = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    if (ex_op == 2'b11) begin
      case (ex_op3)
        6'b000000: begin is_mem = 1'b1; size_word = 1'b1; end
        6'b000001: begin is_mem = 1'b1; end
        6'b000010: begin is_mem = 1'b1; size_half = 1'b1; end
        6'b000100: begin is_mem = 1'b1; size_word = 1'b1; is_store = 1'b1; end
        6'b000101: begin is_mem = 1'b1; is_store = 1'b1; end
        6'b000110: begin is_mem = 1'b1; size_half = 1'b1; is_store = 1'b1; end
        6'b001001: begin is_mem = 1'b1; is_signed = 1'b1; end
        6'b001010: begin is_mem = 1'b1; size_half = 1'b1; is_signed = 1'b1; end
        default:   ;
      endcase
    end
  end

  assign misaligned = is_mem && ((size_word && (addr_lo != 2'b00)) || (size_half && addr_lo[0]));

  assign dmem_req_addr = {ex_alures[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_req_we   = is_store;

  always_comb begin
    if (size_word) begin
      dmem_req_be    = 4'b1111;
      dmem_req_wdata = ex_valD;
    end else if (size_half) begin
      dmem_req_be    = addr_lo[1] ? 4'b0011 : 4'b1100;
      dmem_req_wdata = {2{ex_valD[15:0]}};
    end else begin
      dmem_req_be    = 4'b1000 >> addr_lo;
      dmem_req_wdata = {4{ex_valD[7:0]}};
    end
  end

  // Big-endian lanes: byte 0 lives in rdata[31:24]
  assign byte_lane = 8'(dmem_resp_rdata >> {~addr_lo, 3'b000});
  assign half_lane = 16'(dmem_resp_rdata >> {~addr_lo[1], 4'b0000});

  always_comb begin
    if (size_word)
      load_data = dmem_resp_rdata;
    else if (size_half)
      load_data = {{16{is_signed & half_lane[15]}}, half_lane};
    else
      load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
  end

  always_comb begin
    mem_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    mem_stall = is_mem && !misaligned;
        REQ:     mem_stall = 1'b1;
        WAIT:    mem_stall = !dmem_resp_valid && (wait_cnt != LAST_WAIT);
        default: mem_stall = 1'b0;
      endcase
    end
  end

  assign dmem_req_valid = (state == REQ) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      wb_valid      <= 1'b0;
      wb_regD       <= 5'd0;
      wb_data       <= 32'd0;
      wb_we         <= 1'b0;
      wb_target     <= 64'd0;
      wb_mux_sel    <= 1'b0;
      misalign_trap <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      misalign_trap <= 1'b0;
      bus_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem && !misaligned) begin
            state <= REQ;
          end else begin
            wb_valid      <= 1'b1;
            wb_regD       <= ex_regD;
            wb_data       <= 32'(ex_alures);
            wb_we         <= !is_mem && (ex_regD != 5'd0);
            wb_target     <= ex_target;
            wb_mux_sel    <= ex_mux_sel;
            misalign_trap <= misaligned;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (dmem_resp_valid || (wait_cnt == LAST_WAIT)) begin
            state      <= IDLE;
            wb_valid   <= 1'b1;
            wb_regD    <= ex_regD;
            wb_target  <= ex_target;
            wb_mux_sel <= ex_mux_sel;
            // A response in the last wait cycle still wins over the timeout
            if (dmem_resp_valid) begin
              wb_data <= is_store ? 32'(ex_alures) : load_data;
              wb_we   <= !is_store && (ex_regD != 5'd0);
            end else begin
              wb_data   <= 32'(ex_alures);
              wb_we     <= 1'b0;
              bus_error <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed plus random transaction bench for mem_stage_ctrl with a behavioural model.
module tb_mem_stage_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ex_target;
  logic        ex_mux_sel;
  logic [4:0]  ex_regD;
  logic [31:0] ex_alures;
  logic [1:0]  ex_op;
  logic [2:0]  ex_op2;
  logic [5:0]  ex_op3;
  logic [31:0] ex_valD;
  logic        mem_stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        wb_valid;
  logic [4:0]  wb_regD;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [63:0] wb_target;
  logic        wb_mux_sel;
  logic        misalign_trap;
  logic        bus_error;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .ex_target(ex_target), .ex_mux_sel(ex_mux_sel), .ex_regD(ex_regD),
    .ex_alures(ex_alures), .ex_op(ex_op), .ex_op2(ex_op2), .ex_op3(ex_op3),
    .ex_valD(ex_valD), .mem_stall(mem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_regD(wb_regD), .wb_data(wb_data), .wb_we(wb_we),
    .wb_target(wb_target), .wb_mux_sel(wb_mux_sel),
    .misalign_trap(misalign_trap), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_mem(input logic [1:0] op, input logic [5:0] op3);
    return (op == 2'b11) &&
           (op3 inside {6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0A});
  endfunction

  function automatic int m_size(input logic [5:0] op3);
    if (op3 inside {6'h00, 6'h04}) return 4;
    if (op3 inside {6'h02, 6'h06, 6'h0A}) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int a);
    if (sz == 4) return 4'b1111;
    if (sz == 2) return (a >= 2) ? 4'b0011 : 4'b1100;
    return 4'(8 >> a);
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] vd);
    if (sz == 4) return vd;
    if (sz == 2) return {vd[15:0], vd[15:0]};
    return {vd[7:0], vd[7:0], vd[7:0], vd[7:0]};
  endfunction

  // Bytes are numbered from the MSB end; pick sz bytes starting at byte a
  function automatic logic [31:0] m_load(input int sz, input int a, input bit sg, input logic [31:0] rd);
    longint v;
    longint span;
    span = longint'(1) << (8 * sz);
    v = (longint'(rd) >> (8 * (4 - sz - a))) % span;
    if (sg && (v >= span / 2)) v = v - span;
    return 32'(v);
  endfunction

  task automatic do_txn(input logic [1:0] op, input logic [5:0] op3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] vd, input logic [31:0] rdv,
                        input int rdy_dly, input int rsp_dly, input bit stray);
    bit mem, mis, st, sg, tmo, fin;
    int sz, lo;
    logic [63:0] tgt;
    bit ms;
    tgt = {$urandom, $urandom};
    ms  = 1'($urandom);
    mem = m_is_mem(op, op3);
    sz  = m_size(op3);
    lo  = int'(a[1:0]);
    st  = op3 inside {6'h04, 6'h05, 6'h06};
    sg  = op3 inside {6'h09, 6'h0A};
    mis = mem && ((sz == 4 && lo != 0) || (sz == 2 && (lo % 2) != 0));
    tmo = 1'b0;
    ex_op = op; ex_op3 = op3; ex_regD = rd; ex_alures = a; ex_valD = vd;
    ex_op2 = 3'($urandom); ex_target = tgt; ex_mux_sel = ms;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = stray;
    dmem_resp_rdata = $urandom;
    @(negedge clk);
    chk("present_stall", mem_stall, mem && !mis);
    chk("present_req_valid", dmem_req_valid, 1'b0);
    if (mem && !mis) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        dmem_req_ready = (i == rdy_dly);
        @(negedge clk);
        chk("req_valid", dmem_req_valid, 1'b1);
        chk("req_addr", dmem_req_addr, {a[31:2], 2'b00});
        chk("req_we", dmem_req_we, st);
        chk("req_be", dmem_req_be, m_be(sz, lo));
        chk("req_wdata", dmem_req_wdata, m_wdata(sz, vd));
        chk("req_stall", mem_stall, 1'b1);
        chk("req_wb_valid", wb_valid, 1'b0);
      end
      for (int j = 0; j < TMO; j++) begin
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_resp_valid = (j == rsp_dly);
        dmem_resp_rdata = (j == rsp_dly) ? rdv : $urandom;
        tmo = (j != rsp_dly) && (j == TMO - 1);
        fin = (j == rsp_dly) || tmo;
        @(negedge clk);
        chk("wait_stall", mem_stall, !fin);
        chk("wait_req_valid", dmem_req_valid, 1'b0);
        chk("wait_wb_valid", wb_valid, 1'b0);
        chk("wait_flags", {misalign_trap, bus_error}, 2'b00);
        if (fin) break;
      end
    end
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    dmem_req_ready = 1'b0;
    chk("wb_valid", wb_valid, 1'b1);
    chk("wb_regD", wb_regD, rd);
    chk("wb_target", wb_target, tgt);
    chk("wb_mux_sel", wb_mux_sel, ms);
    chk("misalign_trap", misalign_trap, mis);
    chk("bus_error", bus_error, tmo);
    chk("wb_we", wb_we, (!mem || (!mis && !tmo && !st)) && (rd != 5'd0));
    if (!mem)
      chk("wb_data_pass", wb_data, a);
    else if (!mis && !tmo && !st)
      chk("wb_data_load", wb_data, m_load(sz, lo, sg, rdv));
  endtask

  logic [5:0] valid_op3 [8] = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h09, 6'h0A};

  initial begin
    reset = 1'b1;
    ex_target = '0; ex_mux_sel = 1'b0; ex_regD = '0; ex_alures = '0;
    ex_op = 2'b11; ex_op2 = '0; ex_op3 = 6'h00; ex_valD = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_fields", {wb_regD, wb_data, wb_we, wb_mux_sel}, '0);
    chk("rst_wb_target", wb_target, 64'd0);
    chk("rst_flags", {misalign_trap, bus_error}, 2'b00);
    chk("rst_req_valid", dmem_req_valid, 1'b0);
    reset = 1'b0;

    do_txn(2'b10, 6'h00, 5'd5, 32'h12345678, 32'h0, 32'h0, 0, 0, 1'b1);
    do_txn(2'b10, 6'h00, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 1'b0);
    do_txn(2'b11, 6'h09, 5'd7, 32'h00001001, 32'h0, 32'h00F00000, 0, 0, 1'b0);
    do_txn(2'b11, 6'h06, 5'd9, 32'h00002002, 32'hAAAABEEF, 32'h0, 4, 0, 1'b0);
    do_txn(2'b11, 6'h00, 5'd4, 32'h00003001, 32'h0, 32'h0, 0, 0, 1'b0);
    do_txn(2'b11, 6'h00, 5'd4, 32'h00004000, 32'h0, 32'h0, 0, 99, 1'b0);
    do_txn(2'b10, 6'h00, 5'd6, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 1'b1);
    do_txn(2'b11, 6'h0A, 5'd8, 32'h00005002, 32'h0, 32'h1234F00F, 1, TMO - 1, 1'b0);

    // Abort from WAIT via reset, then a fresh halfword load
    ex_op = 2'b11; ex_op3 = 6'h00; ex_regD = 5'd3; ex_alures = 32'h4000;
    ex_target = 64'h1111_2222_3333_4444; ex_mux_sel = 1'b1;
    @(posedge clk); #1; dmem_req_ready = 1'b1;
    @(posedge clk); #1; dmem_req_ready = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("abort_req_valid", dmem_req_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ex_op = 2'b00; ex_op3 = '0; ex_regD = '0; ex_alures = '0; ex_target = '0; ex_mux_sel = 1'b0;
    chk("abort_wb_valid", wb_valid, 1'b0);
    chk("abort_wb_fields", {wb_regD, wb_data, wb_we, wb_mux_sel, misalign_trap, bus_error}, '0);
    chk("abort_wb_target", wb_target, 64'd0);
    do_txn(2'b11, 6'h02, 5'd10, 32'h00000010, 32'h0, 32'h80011234, 0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [5:0] op3;
      op  = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      op3 = ($urandom_range(0, 9) < 8) ? valid_op3[$urandom_range(0, 7)] : 6'($urandom);
      do_txn(op, op3, 5'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, TMO + 1), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
